des_round_sequencer: RTL and testbench

Iterative DES controller. It sequences one shared combinational round unit through 16 rounds per block. The block owns the L/R state and the C/D key-schedule registers, presents the current round's R half and rotated C‖D to the external round unit (expansion, key mixer/PC-2, S-boxes, P), and folds the returned f-value back in. It sits between the initial-permutation stage and the inverse-initial-permutation stage and replaces the unrolled 16-instance datapath with a single round unit reused over 16 cycles.

---
 rtl/des_round_sequencer.sv | 164 ++++++++++++++++
 tb/tb_des_round_sequencer.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_round_sequencer.sv
// Iterative DES round controller: owns L/R and C/D, reuses one external round unit for 16 cycles.
// Accept to out_valid is 16 edges. The result is held in DONE until out_ready. in_ready is low while busy.
module des_round_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mode,
  input  logic [63:0] block_in,
  input  logic [55:0] key_in,
  output logic [31:0] r_out,
  output logic [55:0] cd_out,
  output logic [3:0]  round_idx,
  input  logic [31:0] f_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] block_out,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] l_q, l_d;
  logic [31:0] r_q, r_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [3:0]  round_q, round_d;
  logic        mode_q, mode_d;

  logic        accept;
  logic        last_round;
  logic [3:0]  next_idx;
  logic [1:0]  esh;
  logic [1:0]  dsh;

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    logic [27:0] y;
    case (n)
      2'd1:    y = {x[26:0], x[27]};
      2'd2:    y = {x[25:0], x[27:26]};
      default: y = x;
    endcase
    return y;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    logic [27:0] y;
    case (n)
      2'd1:    y = {x[0], x[27:1]};
      2'd2:    y = {x[1:0], x[27:2]};
      default: y = x;
    endcase
    return y;
  endfunction

  assign accept     = (state_q == S_IDLE) && in_valid;
  assign last_round = (state_q == S_ROUND) && (round_q == 4'd15);
  assign next_idx   = round_q + 4'd1;

  // Shift amounts for the key of the round about to start (index round+1).
  always_comb begin
    esh = 2'd2;
    dsh = 2'd2;
    case (next_idx)
      4'd0:    begin esh = 2'd1; dsh = 2'd0; end
      4'd1:    begin esh = 2'd1; dsh = 2'd1; end
      4'd8:    begin esh = 2'd1; dsh = 2'd1; end
      4'd15:   begin esh = 2'd1; dsh = 2'd1; end
      default: begin esh = 2'd2; dsh = 2'd2; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_ROUND;
      S_ROUND: if (round_q == 4'd15) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q == S_ROUND) || (state_q == S_DONE);
  end

  always_comb begin
    l_d     = l_q;
    r_d     = r_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    mode_d  = mode_q;
    if (accept) begin
      l_d     = block_in[63:32];
      r_d     = block_in[31:0];
      round_d = 4'd0;
      mode_d  = mode;
      // Encrypt pre-rotates so round 0 already sees K1; decrypt starts from K16 = unrotated.
      if (mode) begin
        c_d = key_in[55:28];
        d_d = key_in[27:0];
      end else begin
        c_d = rotl28(key_in[55:28], 2'd1);
        d_d = rotl28(key_in[27:0], 2'd1);
      end
    end else if (state_q == S_ROUND) begin
      l_d     = r_q;
      r_d     = l_q ^ f_in;
      round_d = next_idx;
      if (!last_round) begin
        if (mode_q) begin
          c_d = rotr28(c_q, dsh);
          d_d = rotr28(d_q, dsh);
        end else begin
          c_d = rotl28(c_q, esh);
          d_d = rotl28(d_q, esh);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      l_q     <= l_d;
      r_q     <= r_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      mode_q  <= mode_d;
    end
  end

  assign r_out     = r_q;
  assign cd_out    = {c_q, d_q};
  assign round_idx = round_q;
  assign block_out = {r_q, l_q};

  a_hold_result: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(block_out)));

endmodule

// File: tb/tb_des_round_sequencer.sv
// Bench for des_round_sequencer: the round unit is emulated combinationally, results checked against a Feistel model.
module tb_des_round_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic [63:0] block_in;
  logic [55:0] key_in;
  logic [31:0] r_out;
  logic [55:0] cd_out;
  logic [3:0]  round_idx;
  logic [31:0] f_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] block_out;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          f_mode = 0;
  logic [31:0] f_seed = 32'h0;

  int ESH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  int DSH [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic [55:0] obs_cd  [16];
  logic [3:0]  obs_idx [16];
  logic [31:0] obs_r   [16];
  logic        early_ov;
  logic        early_rdy;
  logic        done_ov;
  logic [63:0] done_res;

  des_round_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .block_in  (block_in),
    .key_in    (key_in),
    .r_out     (r_out),
    .cd_out    (cd_out),
    .round_idx (round_idx),
    .f_in      (f_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .block_out (block_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fhash(input logic [31:0] r, input logic [55:0] cd,
                                        input logic [3:0] idx, input logic [31:0] seed);
    return (r * 32'h9E3779B1) ^ cd[55:24] ^ {cd[23:0], 4'h0, idx} ^ seed;
  endfunction

  // Stand-in for the external round unit.
  always_comb begin
    case (f_mode)
      0:       f_in = 32'h0;
      1:       f_in = r_out ^ 32'hFFFFFFFF;
      default: f_in = fhash(r_out, cd_out, round_idx, f_seed);
    endcase
  end

  function automatic logic [27:0] rl(input logic [27:0] x, input int n);
    logic [55:0] w;
    w = {x, x} << n;
    return w[55:28];
  endfunction

  // Subkey for round i as a cumulative rotation of the original C0/D0.
  function automatic logic [55:0] model_cd(input logic [55:0] key, input logic md, input int i);
    int s;
    int sh;
    s = 0;
    for (int k = 0; k <= i; k++) s += (md ? DSH[k] : ESH[k]);
    sh = md ? ((28 - (s % 28)) % 28) : (s % 28);
    return {rl(key[55:28], sh), rl(key[27:0], sh)};
  endfunction

  function automatic logic [63:0] model_block(input logic [63:0] blk, input logic [55:0] key,
                                              input logic md, input int fm, input logic [31:0] seed);
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] f;
    logic [31:0] t;
    l = blk[63:32];
    r = blk[31:0];
    for (int i = 0; i < 16; i++) begin
      if (fm == 0)      f = 32'h0;
      else if (fm == 1) f = r ^ 32'hFFFFFFFF;
      else              f = fhash(r, model_cd(key, md, i), 4'(i), seed);
      t = l ^ f;
      l = r;
      r = t;
    end
    return {r, l};
  endfunction

  function automatic logic [55:0] rand_key();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[55:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one job and runs it to the DONE state, recording what the round unit saw.
  task automatic run_job(input logic [63:0] blk, input logic [55:0] key, input logic md, input bit scramble);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_wait: in_ready=%b required 1 within 50 cycles", in_ready);
    end
    block_in = blk;
    key_in   = key;
    mode     = md;
    in_valid = 1'b1;
    tick();
    in_valid  = 1'b0;
    early_ov  = 1'b0;
    early_rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      obs_cd[i]  = cd_out;
      obs_idx[i] = round_idx;
      obs_r[i]   = r_out;
      if (out_valid) early_ov = 1'b1;
      if (in_ready) early_rdy = 1'b1;
      if (scramble) begin
        mode     = ~mode;
        key_in   = rand_key();
        block_in = {$urandom, $urandom};
        in_valid = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    done_ov  = out_valid;
    done_res = block_out;
  endtask

  task automatic release_done();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: in_ready/out_valid/busy=%b required 100", {in_ready, out_valid, busy});
    end
    checks++;
    if (round_idx !== 4'd0 || r_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_idx_r: round_idx=%h r_out=%h required 0 and 0", round_idx, r_out);
    end
    checks++;
    if (cd_out !== 56'h0 || block_out !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: cd_out=%h block_out=%h required 0 and 0", cd_out, block_out);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero_f();
    logic [55:0] key;
    key    = rand_key();
    f_mode = 0;
    run_job(64'h0123456789ABCDEF, key, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (obs_idx[i] !== 4'(i)) begin
        errors++;
        $display("FAIL zero_f_round_idx[%0d]: got %0d required %0d", i, obs_idx[i], i);
      end
    end
    checks++;
    if (early_ov !== 1'b0 || early_rdy !== 1'b0) begin
      errors++;
      $display("FAIL zero_f_rounds: out_valid seen=%b in_ready seen=%b required 0 0", early_ov, early_rdy);
    end
    checks++;
    if (done_ov !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_f_latency: out_valid=%b busy=%b after 16 round edges, required 1 1", done_ov, busy);
    end
    checks++;
    if (done_res !== 64'h89ABCDEF01234567) begin
      errors++;
      $display("FAIL zero_f_result: got %h required 89abcdef01234567", done_res);
    end
    release_done();
  endtask

  task automatic test_key_enc();
    logic [55:0] key;
    key    = {28'h0000001, 28'h0000000};
    f_mode = 2;
    run_job($urandom, key, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (obs_cd[i] !== model_cd(key, 1'b0, i)) begin
        errors++;
        $display("FAIL enc_cd[%0d]: got %h required %h", i, obs_cd[i], model_cd(key, 1'b0, i));
      end
    end
    checks++;
    if (obs_cd[0][55:28] !== 28'h2 || obs_cd[1][55:28] !== 28'h4 ||
        obs_cd[2][55:28] !== 28'h10 || obs_cd[15][55:28] !== 28'h1) begin
      errors++;
      $display("FAIL enc_c_directed: C r0/r1/r2/r15=%h/%h/%h/%h required 2/4/10/1",
               obs_cd[0][55:28], obs_cd[1][55:28], obs_cd[2][55:28], obs_cd[15][55:28]);
    end
    release_done();
  endtask

  task automatic test_key_dec();
    logic [55:0] key;
    logic [63:0] blk;
    logic [63:0] exp;
    key    = {28'h0000001, 28'h0000000};
    blk    = {$urandom, $urandom};
    f_mode = 2;
    exp    = model_block(blk, key, 1'b1, 2, f_seed);
    run_job(blk, key, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (obs_cd[i] !== model_cd(key, 1'b0, 15 - i)) begin
        errors++;
        $display("FAIL dec_cd_reversed[%0d]: got %h required %h", i, obs_cd[i], model_cd(key, 1'b0, 15 - i));
      end
    end
    checks++;
    if (obs_cd[0][55:28] !== 28'h1 || obs_cd[1][55:28] !== 28'h8000000 || obs_cd[2][55:28] !== 28'h2000000) begin
      errors++;
      $display("FAIL dec_c_directed: C r0/r1/r2=%h/%h/%h required 1/8000000/2000000",
               obs_cd[0][55:28], obs_cd[1][55:28], obs_cd[2][55:28]);
    end
    checks++;
    if (done_res !== exp) begin
      errors++;
      $display("FAIL dec_result: got %h required %h", done_res, exp);
    end
    release_done();
  endtask

  task automatic test_round_arith();
    logic [55:0] key;
    logic [63:0] exp;
    key    = rand_key();
    f_mode = 1;
    exp    = model_block(64'h0, key, 1'b0, 1, f_seed);
    run_job(64'h0, key, 1'b0, 1'b0);
    checks++;
    if (obs_r[0] !== 32'h0 || obs_r[1] !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL arith_first_round: R r0/r1=%h/%h required 00000000/ffffffff", obs_r[0], obs_r[1]);
    end
    checks++;
    if (done_res !== exp) begin
      errors++;
      $display("FAIL arith_result: got %h required %h", done_res, exp);
    end
    release_done();
  endtask

  task automatic test_random();
    logic [63:0] blk;
    logic [55:0] key;
    logic        md;
    logic [63:0] exp;
    f_mode = 2;
    for (int j = 0; j < 8; j++) begin
      blk = {$urandom, $urandom};
      key = rand_key();
      md  = 1'($urandom_range(1, 0));
      exp = model_block(blk, key, md, 2, f_seed);
      run_job(blk, key, md, 1'b0);
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (obs_cd[i] !== model_cd(key, md, i)) begin
          errors++;
          $display("FAIL random_cd[%0d][%0d]: got %h required %h", j, i, obs_cd[i], model_cd(key, md, i));
        end
      end
      checks++;
      if (done_ov !== 1'b1 || done_res !== exp) begin
        errors++;
        $display("FAIL random_result[%0d]: valid=%b got %h required %h", j, done_ov, done_res, exp);
      end
      release_done();
    end
  endtask

  task automatic test_scramble();
    logic [63:0] blk;
    logic [55:0] key;
    logic [63:0] exp;
    f_mode = 2;
    blk    = {$urandom, $urandom};
    key    = rand_key();
    exp    = model_block(blk, key, 1'b0, 2, f_seed);
    run_job(blk, key, 1'b0, 1'b1);
    checks++;
    if (done_ov !== 1'b1 || done_res !== exp) begin
      errors++;
      $display("FAIL scramble_result: valid=%b got %h required %h", done_ov, done_res, exp);
    end
    release_done();
  endtask

  task automatic test_handshake();
    logic [63:0] blk_a;
    logic [63:0] blk_b;
    logic [55:0] key_a;
    logic [55:0] key_b;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
    f_mode = 2;
    blk_a  = {$urandom, $urandom};
    key_a  = rand_key();
    blk_b  = {$urandom, $urandom};
    key_b  = rand_key();
    exp_a  = model_block(blk_a, key_a, 1'b1, 2, f_seed);
    exp_b  = model_block(blk_b, key_b, 1'b0, 2, f_seed);
    run_job(blk_a, key_a, 1'b1, 1'b0);
    checks++;
    if (done_res !== exp_a) begin
      errors++;
      $display("FAIL hs_result_a: got %h required %h", done_res, exp_a);
    end
    block_in = blk_b;
    key_in   = key_b;
    mode     = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || block_out !== exp_a) begin
        errors++;
        $display("FAIL hs_hold[%0d]: out_valid=%b in_ready=%b block_out=%h required 1 0 %h",
                 i, out_valid, in_ready, block_out, exp_a);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hs_to_idle: in_ready=%b out_valid=%b busy=%b required 1 0 0", in_ready, out_valid, busy);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || round_idx !== 4'd0) begin
      errors++;
      $display("FAIL hs_next_accept: busy=%b in_ready=%b round_idx=%0d required 1 0 0", busy, in_ready, round_idx);
    end
    for (int i = 0; i < 16; i++) tick();
    checks++;
    if (out_valid !== 1'b1 || block_out !== exp_b) begin
      errors++;
      $display("FAIL hs_result_b: valid=%b got %h required %h", out_valid, block_out, exp_b);
    end
    release_done();
  endtask

  task automatic test_reset_mid();
    logic seen_ov;
    f_mode   = 2;
    block_in = {$urandom, $urandom};
    key_in   = rand_key();
    mode     = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (round_idx !== 4'd7) begin
      errors++;
      $display("FAIL midrst_round: round_idx=%0d required 7", round_idx);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || round_idx !== 4'd0 || block_out !== 64'h0) begin
      errors++;
      $display("FAIL midrst_state: rdy/ov/busy=%b round_idx=%0d block_out=%h required 100 0 0",
               {in_ready, out_valid, busy}, round_idx, block_out);
    end
    seen_ov = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen_ov = 1'b1;
    end
    checks++;
    if (seen_ov !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_valid: out_valid seen=%b required 0", seen_ov);
    end
  endtask

  task automatic test_back_to_back();
    int   rises [$];
    logic prev_busy;
    int   n;
    f_mode    = 2;
    block_in  = {$urandom, $urandom};
    key_in    = rand_key();
    mode      = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    prev_busy = busy;
    for (int c = 0; c < 45; c++) begin
      tick();
      if (busy && !prev_busy) rises.push_back(c);
      prev_busy = busy;
    end
    in_valid = 1'b0;
    checks++;
    if (rises.size() < 2) begin
      errors++;
      $display("FAIL b2b_accepts: accepts seen=%0d required at least 2", rises.size());
    end else if (rises[1] - rises[0] != 18) begin
      errors++;
      $display("FAIL b2b_period: accept spacing=%0d required 18", rises[1] - rises[0]);
    end
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mode      = 1'b0;
    block_in  = 64'h0;
    key_in    = 56'h0;
    f_seed    = $urandom;
    test_reset();
    test_zero_f();
    test_key_enc();
    test_key_dec();
    test_round_arith();
    test_random();
    test_scramble();
    test_handshake();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
